// File: rtl/seg_pkg.sv
// Shared constants and types for the 7-segment scan reader.
// Segment bit order: bit 6 = a, bit 5 = b, ... bit 0 = g. Active-low (0 = lit).
package seg_pkg;

  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1001100;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0100000;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0001111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0000100;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  typedef enum logic {
    SETTLE = 1'b0,
    HOLD   = 1'b1
  } stab_state_t;

endpackage

// File: rtl/seg_to_num_4b.sv
// Combinational inverse of the 7-segment display encoder.
module seg_to_num_4b
  import seg_pkg::*;
(
  input  logic [SEG_W-1:0] sseg,
  output logic [3:0]       num,
  output logic             is_blank,
  output logic             illegal
);

  // Glyph lookup; anything outside the digit table and all-off is illegal.
  always_comb begin
    num      = 4'h0;
    is_blank = 1'b0;
    illegal  = 1'b0;
    case (sseg)
      SEG_0:     num = 4'd0;
      SEG_1:     num = 4'd1;
      SEG_2:     num = 4'd2;
      SEG_3:     num = 4'd3;
      SEG_4:     num = 4'd4;
      SEG_5:     num = 4'd5;
      SEG_6:     num = 4'd6;
      SEG_7:     num = 4'd7;
      SEG_8:     num = 4'd8;
      SEG_9:     num = 4'd9;
      SEG_BLANK: begin
        num      = BLANK_CODE;
        is_blank = 1'b1;
      end
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_reader.sv
// Passive reader for a multiplexed active-low 7-segment bus. Waits for the
// anode/segment pair to settle, decodes the glyph and assembles a frame once
// every digit position has been captured.
module seg_scan_reader
  import seg_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIGITS-1:0]     an,
  input  logic [SEG_W-1:0]      sseg,
  output logic [4*DIGITS-1:0]   digits,
  output logic [DIGITS-1:0]     blank,
  output logic                  frame_valid,
  output logic                  seg_err,
  output logic                  an_err
);

  localparam int BUS_W = DIGITS + SEG_W;
  localparam int CW    = $clog2(STABLE_CYCLES + 1);
  localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic [BUS_W-1:0] s1_reg, s2_reg, s3_reg;
  stab_state_t      state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             capture;

  logic [4*DIGITS-1:0] digits_reg, digits_next;
  logic [DIGITS-1:0]   blank_reg, blank_next;
  logic [DIGITS-1:0]   seen_reg, seen_next;
  logic                frame_reg, frame_next;
  logic                seg_err_reg, seg_err_next;
  logic                an_err_reg, an_err_next;

  logic [DIGITS-1:0] an_s;
  logic [SEG_W-1:0]  sg_s;
  logic [3:0]        dec_num;
  logic              dec_blank, dec_illegal;
  logic [3:0]        zeros;
  logic [IW-1:0]     idx;
  logic [DIGITS-1:0] seen_tmp;

  assign an_s = s2_reg[BUS_W-1:SEG_W];
  assign sg_s = s2_reg[SEG_W-1:0];

  seg_to_num_4b u_dec (
    .sseg     (sg_s),
    .num      (dec_num),
    .is_blank (dec_blank),
    .illegal  (dec_illegal)
  );

  // Two-flop synchroniser for the asynchronous bus plus a delayed copy for change detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_reg <= '1;
      s2_reg <= '1;
      s3_reg <= '1;
    end else begin
      s1_reg <= {an, sseg};
      s2_reg <= s1_reg;
      s3_reg <= s2_reg;
    end
  end

  // Stability FSM state and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= SETTLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Stability FSM: count unchanged cycles, capture once, then hold until the bus moves.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    capture    = 1'b0;
    case (state_reg)
      SETTLE: begin
        if (s2_reg != s3_reg) begin
          cnt_next = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == CNT_LAST) begin
            capture    = 1'b1;
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (s2_reg != s3_reg) begin
          cnt_next   = '0;
          state_next = SETTLE;
        end
      end
      default: state_next = SETTLE;
    endcase
  end

  // Count active anodes and locate the selected position.
  always_comb begin
    zeros = 4'd0;
    idx   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!an_s[i]) begin
        zeros = zeros + 4'd1;
        idx   = IW'(i);
      end
    end
  end

  // Capture action: update the selected digit, track seen positions, raise pulses.
  always_comb begin
    digits_next  = digits_reg;
    blank_next   = blank_reg;
    seen_next    = seen_reg;
    seen_tmp     = seen_reg;
    frame_next   = 1'b0;
    seg_err_next = 1'b0;
    an_err_next  = 1'b0;
    if (capture) begin
      if (zeros > 4'd1) begin
        an_err_next = 1'b1;
      end else if (zeros == 4'd1) begin
        if (dec_illegal) begin
          seg_err_next = 1'b1;
        end else begin
          digits_next[{idx, 2'b00} +: 4] = dec_num;
          blank_next[idx]                = dec_blank;
          seen_tmp[idx]                  = 1'b1;
          if (&seen_tmp) begin
            frame_next = 1'b1;
            seen_next  = '0;
          end else begin
            seen_next  = seen_tmp;
          end
        end
      end
    end
  end

  // Output and frame-tracking registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_reg  <= '0;
      blank_reg   <= '0;
      seen_reg    <= '0;
      frame_reg   <= 1'b0;
      seg_err_reg <= 1'b0;
      an_err_reg  <= 1'b0;
    end else begin
      digits_reg  <= digits_next;
      blank_reg   <= blank_next;
      seen_reg    <= seen_next;
      frame_reg   <= frame_next;
      seg_err_reg <= seg_err_next;
      an_err_reg  <= an_err_next;
    end
  end

  assign digits      = digits_reg;
  assign blank       = blank_reg;
  assign frame_valid = frame_reg;
  assign seg_err     = seg_err_reg;
  assign an_err      = an_err_reg;

endmodule
